// File: rtl/align_pipe_if.sv
// Handshake and operand/result bundle for align_pipe.
// The slave modport is the aligner side; the master modport drives operands and consumes results.
interface align_pipe_if #(
    parameter int SIG_WIDTH   = 23,
    parameter int SHAMT_WIDTH = 7,
    parameter int TAG_WIDTH   = 4
);
    localparam int W = 3 * (SIG_WIDTH + 1) + 7;

    logic                   in_valid;
    logic                   in_ready;
    logic [SIG_WIDTH:0]     C;
    logic                   cSign;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [TAG_WIDTH-1:0]   in_tag;

    logic                   out_valid;
    logic                   out_ready;
    logic [W-1:0]           CAligned;
    logic                   sticky;
    logic [TAG_WIDTH-1:0]   out_tag;

    modport master (
        output in_valid, C, cSign, shamt, in_tag, out_ready,
        input  in_ready, out_valid, CAligned, sticky, out_tag
    );

    modport slave (
        input  in_valid, C, cSign, shamt, in_tag, out_ready,
        output in_ready, out_valid, CAligned, sticky, out_tag
    );
endinterface

// File: rtl/align_pipe.sv
// Two-stage addend aligner: coarse (multiple-of-8) shift in stage 1, fine shift,
// conditional inversion and final sticky in stage 2, with valid/ready flow control.
module align_pipe #(
    parameter int SIG_WIDTH   = 23,
    parameter int SHAMT_WIDTH = 7,
    parameter int TAG_WIDTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    align_pipe_if.slave bus
);
    localparam int W         = 3 * (SIG_WIDTH + 1) + 7;
    localparam int LOW_ZEROS = W - SIG_WIDTH - 3;

    logic [W-1:0]           ones;
    logic [W-1:0]           window;
    logic [SHAMT_WIDTH-1:0] coarse_amt;

    logic                   s1_valid_q, s1_valid_d;
    logic [W-1:0]           s1_data_q, s1_data_d;
    logic                   s1_sticky_q, s1_sticky_d;
    logic [2:0]             s1_fine_q, s1_fine_d;
    logic                   s1_sign_q, s1_sign_d;
    logic [TAG_WIDTH-1:0]   s1_tag_q, s1_tag_d;

    logic                   s2_valid_q, s2_valid_d;
    logic [W-1:0]           s2_data_q, s2_data_d;
    logic                   s2_sticky_q, s2_sticky_d;
    logic [TAG_WIDTH-1:0]   s2_tag_q, s2_tag_d;

    logic                   s1_adv, s2_adv;

    assign ones       = '1;
    assign window     = {2'b00, bus.C, {LOW_ZEROS{1'b0}}};
    assign coarse_amt = {bus.shamt[SHAMT_WIDTH-1:3], 3'b000};

    assign s2_adv = !s2_valid_q || bus.out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_sticky_d = s1_sticky_q;
        s1_fine_d   = s1_fine_q;
        s1_sign_d   = s1_sign_q;
        s1_tag_d    = s1_tag_q;
        if (s1_adv) begin
            s1_valid_d  = bus.in_valid;
            s1_data_d   = window >> coarse_amt;
            // Mask of the bits dropped by the coarse shift; saturates to all ones when coarse_amt >= W.
            s1_sticky_d = |(window & ~(ones << coarse_amt));
            s1_fine_d   = bus.shamt[2:0];
            s1_sign_d   = bus.cSign;
            s1_tag_d    = bus.in_tag;
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_sticky_d = s2_sticky_q;
        s2_tag_d    = s2_tag_q;
        if (s2_adv) begin
            s2_valid_d  = s1_valid_q;
            s2_data_d   = (s1_data_q >> s1_fine_q) ^ {W{s1_sign_q}};
            s2_sticky_d = s1_sticky_q | (|(s1_data_q & ~(ones << s1_fine_q)));
            s2_tag_d    = s1_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_data_q   <= s1_data_d;
        s1_sticky_q <= s1_sticky_d;
        s1_fine_q   <= s1_fine_d;
        s1_sign_q   <= s1_sign_d;
        s1_tag_q    <= s1_tag_d;
        s2_data_q   <= s2_data_d;
        s2_sticky_q <= s2_sticky_d;
        s2_tag_q    <= s2_tag_d;
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.CAligned  = s2_data_q;
    assign bus.sticky    = s2_sticky_q;
    assign bus.out_tag   = s2_tag_q;
endmodule

// File: doc/align_pipe.md
ALIGN_PIPE -- requirements
Module: align_pipe

Interface
REQ-001 Parameter SIG_WIDTH, default 23, significand fraction width; C operand is SIG_WIDTH+1 bits.
REQ-002 Parameter SHAMT_WIDTH, default 7, shift-amount width.
REQ-003 Parameter TAG_WIDTH, default 4, width of a sideband tag carried alongside each operand.
REQ-004 Derived constant W = 3*(SIG_WIDTH+1)+7, the aligned output width; W = 79 at defaults.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  input operand present.
REQ-008 in_ready  output  1  block accepts the operand this cycle.
REQ-009 C  input  SIG_WIDTH+1  addend significand.
REQ-010 cSign  input  1  effective subtraction; output is one's-complemented when set.
REQ-011 shamt  input  SHAMT_WIDTH  right-shift amount.
REQ-012 in_tag  input  TAG_WIDTH  sideband, returned unmodified.
REQ-013 out_valid  output  1  aligned result present.
REQ-014 out_ready  input  1  consumer accepts the result this cycle.
REQ-015 CAligned  output  W  aligned, conditionally inverted addend.
REQ-016 sticky  output  1  OR of all C bits shifted below bit 0 of the window.
REQ-017 out_tag  output  TAG_WIDTH  tag of the result on CAligned.

Function
REQ-018 Pre-shift window is {2'b00, C, (W-SIG_WIDTH-3) zero bits}; C MSB sits at bit W-3.
REQ-019 CAligned is the window logically right-shifted by shamt, then bitwise inverted when cSign=1.
REQ-020 sticky is the OR of the window bits that fall below bit 0, computed on the uninverted value; cSign never affects sticky.
REQ-021 shamt >= W: pre-inversion window is all zeros and sticky = |C.
REQ-022 Two pipeline stages: stage 1 registers the coarse shift (shamt bits above bit 2) plus the partial sticky; stage 2 registers the fine shift (shamt[2:0]), the inversion, and the final sticky.
REQ-023 A transfer occurs on in_valid&&in_ready at the input and on out_valid&&out_ready at the output.
REQ-024 Stage 2 advances when it is empty or out_ready=1; stage 1 advances when it is empty or stage 2 advances; in_ready equals the stage-1 advance condition.
REQ-025 Latency is exactly 2 cycles from input transfer to out_valid with no stall; throughput is one operand per cycle.
REQ-026 While out_valid=1 and out_ready=0, CAligned, sticky and out_tag hold stable.
REQ-027 No operand is dropped or duplicated; results leave in acceptance order with their own tag.
REQ-028 When both stages are full and out_ready=0, in_ready=0.
REQ-029 An input transfer and an output transfer in the same cycle on a full pipe are both honoured with no bubble.
REQ-030 Stage data registers need no reset; only valid flags are reset.

Reset
REQ-031 rst_n low clears both stage valid flags immediately, regardless of clk: out_valid=0 and in_ready=1.
REQ-032 Operands in flight when rst_n asserts are discarded; after release the first accepted operand appears 2 cycles later.
REQ-033 CAligned, sticky and out_tag carry no meaning while out_valid=0.

Verification (defaults, W=79)
REQ-034 C=24'h800000, shamt=0, cSign=0, tag=3, out_ready=1 -> 2 cycles later out_valid=1, CAligned has only bit 76 set, sticky=0, out_tag=3.
REQ-035 C=24'hFFFFFF, shamt=60, cSign=0 -> CAligned bits 16..0 set and the rest 0, sticky=1.
REQ-036 C=24'h000001, shamt=127, cSign=1 -> CAligned all ones, sticky=1; C=0, shamt=0, cSign=1 -> all ones, sticky=0.
REQ-037 Back-to-back operands A,B,C with out_ready=0 for 4 cycles -> in_ready drops after A and B fill the stages, A is held stable, and results emerge in the order A,B,C once out_ready=1, one per cycle.
REQ-038 rst_n pulsed low mid-cycle with both stages full -> out_valid falls without a clock edge, and neither in-flight result ever appears; the next operand emerges 2 cycles after acceptance.
REQ-039 Random stress: 10k operands with random shamt, cSign and out_ready toggling -> every result matches the reference model of REQ-018..021, and tags come back in order.
